// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-path types: widths, queue entry layouts and a PC alignment helper.
package riscv_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   misalign;
  } fetch_entry_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                misalign;
  } addr_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_chk.sv
// Simulation checks on the fetch queue's memory handshake and internal bookkeeping.
module instr_fetch_queue_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          mem_rvalid_i,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] discard_i,
  input logic [CW-1:0] addr_count_i,
  input logic          addr_empty_i,
  input logic          addr_full_i,
  input logic          keep_i,
  input logic          data_full_i,
  input logic          pc_ready_i
);

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    mem_rvalid_i |-> (outstanding_i != {CW{1'b0}}))
    else $error("instr_fetch_queue: mem_rvalid with no request outstanding");

  a_addr_tracks_live: assert property (@(posedge clk) disable iff (rst)
    addr_count_i == (outstanding_i - discard_i))
    else $error("instr_fetch_queue: address queue out of step with live requests");

  a_keep_has_addr: assert property (@(posedge clk) disable iff (rst)
    keep_i |-> !addr_empty_i)
    else $error("instr_fetch_queue: response kept with no address queued");

  a_full_stalls_pc: assert property (@(posedge clk) disable iff (rst)
    (data_full_i || addr_full_i) |-> !pc_ready_i)
    else $error("instr_fetch_queue: PC accepted while a queue is full");

endmodule

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with a clear input; a push into a full FIFO is taken only
// when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else if (clear_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      count_q <= count_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
    end
  end

  // Storage write port; contents are never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue between program counter, instruction memory and decode: issues reads,
// pairs responses with their PCs in order, and discards wrong-path fetches on flush.
module instr_fetch_queue #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_valid,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [PC_WIDTH-3:0]    mem_addr,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_misalign
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          active_s;
  logic          accept_s;
  logic          rsp_s;
  logic          drop_s;
  logic          keep_s;
  logic          pop_s;
  logic [CW:0]   occ_s;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] addr_count_s, data_count_s;
  logic          addr_full_s, addr_empty_s, data_full_s, data_empty_s;
  addr_entry_t   addr_wdata_s, addr_rdata_s;
  fetch_entry_t  data_wdata_s, data_rdata_s;

  assign active_s = !rst;
  assign occ_s    = {1'b0, data_count_s} + {1'b0, outstanding_q};
  assign pc_ready = active_s && !flush && (occ_s < (CW+1)'(DEPTH));
  assign accept_s = pc_valid && pc_ready;
  assign mem_req  = accept_s;
  assign mem_addr = accept_s ? pc[PC_WIDTH-1:2] : {(PC_WIDTH-2){1'b0}};

  // A response arriving during flush belongs to the discarded path as well.
  assign rsp_s  = active_s && mem_rvalid && (outstanding_q != {CW{1'b0}});
  assign drop_s = rsp_s && (flush || (discard_q != {CW{1'b0}}));
  assign keep_s = rsp_s && !drop_s;

  assign instr_valid    = active_s && !data_empty_s;
  assign pop_s          = instr_valid && instr_ready && !flush;
  assign instr          = instr_valid ? data_rdata_s.instr : {INSTR_WIDTH{1'b0}};
  assign instr_pc       = instr_valid ? data_rdata_s.pc : {PC_WIDTH{1'b0}};
  assign instr_misalign = instr_valid && data_rdata_s.misalign;

  assign addr_wdata_s = '{pc: pc, misalign: pc_misaligned(pc[1:0])};
  assign data_wdata_s = '{instr: mem_rdata, pc: addr_rdata_s.pc, misalign: addr_rdata_s.misalign};

  sync_fifo #(.WIDTH($bits(addr_entry_t)), .DEPTH(DEPTH)) u_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept_s),
    .pop_i   (keep_s),
    .clear_i (flush),
    .wdata_i (addr_wdata_s),
    .rdata_o (addr_rdata_s),
    .full_o  (addr_full_s),
    .empty_o (addr_empty_s),
    .count_o (addr_count_s)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep_s),
    .pop_i   (pop_s),
    .clear_i (flush),
    .wdata_i (data_wdata_s),
    .rdata_o (data_rdata_s),
    .full_o  (data_full_s),
    .empty_o (data_empty_s),
    .count_o (data_count_s)
  );

  // Next in-flight and to-be-discarded counts; flush turns every live request into a discard.
  always_comb begin
    outstanding_d = outstanding_q + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, rsp_s};
    discard_d     = discard_q;
    if (flush) begin
      discard_d = outstanding_d;
    end else if (drop_s) begin
      discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      discard_d = discard_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  instr_fetch_queue_chk #(.CW(CW)) u_chk (
    .clk           (clk),
    .rst           (rst),
    .mem_rvalid_i  (mem_rvalid),
    .outstanding_i (outstanding_q),
    .discard_i     (discard_q),
    .addr_count_i  (addr_count_s),
    .addr_empty_i  (addr_empty_s),
    .addr_full_i   (addr_full_s),
    .keep_i        (keep_s),
    .data_full_i   (data_full_s),
    .pc_ready_i    (pc_ready)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic against a
// transaction-level model of live fetches and an in-order variable-latency memory.
module tb_instr_fetch_queue;

  localparam int PW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_valid;
  logic [PW-1:0] pc;
  logic          pc_ready;
  logic          flush;
  logic          mem_req;
  logic [PW-3:0] mem_addr;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [PW-1:0] instr_pc;
  logic          instr_misalign;

  typedef struct { logic [PW-1:0] pc; bit arrived; logic [IW-1:0] data; } live_t;
  typedef struct { logic [PW-1:0] pc; int ready; bit dead; } mreq_t;
  typedef struct { logic [PW-1:0] pc; logic mis; } pop_t;

  live_t live[$];     // accepted fetches not yet delivered or flushed, oldest first
  mreq_t mq[$];       // requests the memory still owes a response for
  pop_t  pop_log[$];  // entries decode actually consumed

  int            cyc, checks, errors, req_cnt, lat_lo, lat_hi;
  logic          last_req;
  logic [PW-3:0] last_addr;

  always #5 clk = ~clk;

  instr_fetch_queue #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_misalign(instr_misalign)
  );

  function automatic logic [IW-1:0] mem_word(input logic [PW-3:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic int occupancy();
    int n = live.size();
    foreach (mq[i]) if (mq[i].dead) n++;
    return n;
  endfunction

  function automatic logic [PW-1:0] log_pc(input int i);
    if (i < pop_log.size()) return pop_log[i].pc;
    else return 16'hFFFF;
  endfunction

  function automatic logic log_mis(input int i);
    if (i < pop_log.size()) return pop_log[i].mis;
    else return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input logic [PW-1:0] p, input bit fl, input bit rdy);
    bit    rsp, exp_ready, exp_valid, acc;
    mreq_t m;
    rsp         = (mq.size() > 0) && (mq[0].ready <= cyc);
    pc_valid    = v;
    pc          = p;
    flush       = fl;
    instr_ready = rdy;
    mem_rvalid  = rsp;
    mem_rdata   = rsp ? mem_word(mq[0].pc[PW-1:2]) : IW'($urandom());
    #1;
    exp_ready = !fl && (occupancy() < DEPTH);
    acc       = v && exp_ready;
    exp_valid = (live.size() > 0) && live[0].arrived;
    chk("pc_ready", 64'(pc_ready), 64'(exp_ready));
    chk("mem_req", 64'(mem_req), 64'(acc));
    if (acc) chk("mem_addr", 64'(mem_addr), 64'(p[PW-1:2]));
    chk("instr_valid", 64'(instr_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("instr", 64'(instr), 64'(live[0].data));
      chk("instr_pc", 64'(instr_pc), 64'(live[0].pc));
      chk("instr_misalign", 64'(instr_misalign), 64'(|live[0].pc[1:0]));
    end
    last_req  = mem_req;
    last_addr = mem_addr;
    if (mem_req === 1'b1) req_cnt++;
    if (!fl && rdy && instr_valid === 1'b1) pop_log.push_back('{pc: instr_pc, mis: instr_misalign});
    if (rsp) begin
      m = mq.pop_front();
      if (!m.dead) begin
        for (int i = 0; i < live.size(); i++) begin
          if (!live[i].arrived) begin
            live[i].arrived = 1'b1;
            live[i].data    = mem_word(m.pc[PW-1:2]);
            break;
          end
        end
      end
    end
    if (fl) begin
      live.delete();
      foreach (mq[i]) mq[i].dead = 1'b1;
    end else if (exp_valid && rdy) begin
      void'(live.pop_front());
    end
    if (acc) begin
      live.push_back('{pc: p, arrived: 1'b0, data: 32'h0});
      mq.push_back('{pc: p, ready: cyc + int'($urandom_range(lat_hi, lat_lo)), dead: 1'b0});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic reset_pulse();
    pc_valid    = 1'b1;
    pc          = 16'h0100;
    instr_ready = 1'b1;
    flush       = 1'b0;
    mem_rvalid  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_misalign", 64'(instr_misalign), 64'd0);
    pc_valid    = 1'b0;
    instr_ready = 1'b0;
    live.delete();
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pc_ready", 64'(pc_ready), 64'd1);
    chk("post_rst_instr_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] rp;
    rst = 1'b1; pc_valid = 1'b0; pc = 16'h0; flush = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; instr_ready = 1'b0;
    cyc = 0; checks = 0; errors = 0; req_cnt = 0; lat_lo = 1; lat_hi = 1;
    last_req = 1'b0; last_addr = 14'h0;
    @(negedge clk);
    reset_pulse();

    // Streaming with single-cycle memory
    pop_log.delete();
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h0004, 1'b0, 1'b1);
    step(1'b1, 16'h0008, 1'b0, 1'b1);
    step(1'b1, 16'h000C, 1'b0, 1'b1);
    idle(4);
    chk("stream_count", 64'(pop_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("stream_order", 64'(log_pc(i)), 64'(4 * i));

    // Back-pressure: decode stalled
    req_cnt = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0010 + 4 * i), 1'b0, 1'b0);
    chk("bp_accepts", 64'(req_cnt), 64'd4);
    req_cnt = 0;
    step(1'b1, 16'h0030, 1'b0, 1'b1);
    step(1'b1, 16'h0030, 1'b0, 1'b0);
    step(1'b1, 16'h0034, 1'b0, 1'b0);
    chk("bp_one_more", 64'(req_cnt), 64'd1);
    idle(10);

    // Flush with two fetches in flight, 3-cycle memory
    lat_lo = 3; lat_hi = 3;
    pop_log.delete();
    step(1'b1, 16'h0020, 1'b0, 1'b1);
    step(1'b1, 16'h0024, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h0040, 1'b0, 1'b1);
    idle(8);
    chk("flush_first_out", 64'(log_pc(0)), 64'h40);
    chk("flush_survivors", 64'(pop_log.size()), 64'd1);

    // Flush coinciding with a response and a PC offer, 2-cycle memory
    lat_lo = 2; lat_hi = 2;
    pop_log.delete();
    step(1'b1, 16'h0050, 1'b0, 1'b1);
    step(1'b1, 16'h0054, 1'b0, 1'b1);
    step(1'b1, 16'h0058, 1'b1, 1'b1);
    chk("flush_no_accept", 64'(last_req), 64'd0);
    step(1'b1, 16'h0060, 1'b0, 1'b1);
    idle(8);
    chk("flush2_first_out", 64'(log_pc(0)), 64'h60);
    chk("flush2_survivors", 64'(pop_log.size()), 64'd1);

    // Misaligned PC
    lat_lo = 1; lat_hi = 1;
    pop_log.delete();
    step(1'b1, 16'h0006, 1'b0, 1'b1);
    chk("mis_mem_addr", 64'(last_addr), 64'h1);
    idle(4);
    chk("mis_pc", 64'(log_pc(0)), 64'h6);
    chk("mis_flag", 64'(log_mis(0)), 64'd1);

    // Random traffic with variable latency, interrupted by a reset
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) reset_pulse();
      rp = 16'($urandom());
      if ($urandom_range(7, 0) != 0) rp[1:0] = 2'b00;
      step($urandom_range(3, 0) != 0, rp, $urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0);
    end
    idle(12);
    chk("drained", 64'(live.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
